pipe_adder: RTL and testbench

Pipelined, carry-chunked unsigned adder that serves as the device under test in the adder test suites. It sits directly downstream of the bench stimulus master. It accepts operand pairs over a valid/ready handshake, splits the carry chain across STAGES register stages, and returns the (DATA_WIDTH+1)-bit sum with a fixed latency. The whole pipeline stalls under output backpressure.

---
 rtl/pipe_adder_if.sv | 23 ++
 rtl/pipe_adder.sv | 138 +++++++++++++
 tb/tb_pipe_adder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder. The master side drives operands and
// consumes results; the slave side is the adder itself.
interface pipe_adder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   out_sum;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined carry-chunked unsigned adder. Stage k adds one CHUNK-wide slice of the operands
// plus the carry registered by stage k-1; the whole pipe stalls on output backpressure.
// Optional statistics counters are built when PIPE_ADDER_STATS_EN is defined.
module pipe_adder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_adder_if.slave bus
`ifdef PIPE_ADDER_STATS_EN
  ,
  output logic [31:0] op_count_o,
  output logic [31:0] carry_count_o
`endif
);

  localparam int unsigned Chunk = (DATA_WIDTH + STAGES - 1) / STAGES;

  // Width of the slice added by stage k; the last stage takes whatever is left, and
  // stages past the top bit (possible when STAGES is close to DATA_WIDTH) add nothing.
  function automatic int unsigned chunk_width(int unsigned k);
    int unsigned lo;
    int unsigned hi;
    lo = k * Chunk;
    if (lo >= DATA_WIDTH) return 0;
    hi = (k == STAGES - 1) ? DATA_WIDTH : lo + Chunk;
    if (hi > DATA_WIDTH) hi = DATA_WIDTH;
    return hi - lo;
  endfunction

  logic adv;
  logic accept;

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [STAGES-1:0]     carry_q, carry_d;
  // Operands are kept right-justified: already-added low bits are shifted out.
  logic [DATA_WIDTH-1:0] a_q   [STAGES];
  logic [DATA_WIDTH-1:0] a_d   [STAGES];
  logic [DATA_WIDTH-1:0] b_q   [STAGES];
  logic [DATA_WIDTH-1:0] b_d   [STAGES];
  // Partial sums fill in from the top and shift down, so the final stage is aligned.
  logic [DATA_WIDTH-1:0] sum_q [STAGES];
  logic [DATA_WIDTH-1:0] sum_d [STAGES];

  assign adv          = !(valid_q[STAGES-1] && !bus.out_ready);
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_sum   = {carry_q[STAGES-1], sum_q[STAGES-1]};

  // Per-stage chunk add: slice of the skewed operands plus the previous stage's carry.
  always_comb begin
    logic [DATA_WIDTH-1:0] a_src, b_src, sum_src, chunk;
    logic [DATA_WIDTH:0]   mask, part;
    logic                  cin;
    int unsigned           w;
    valid_d = '0;
    carry_d = '0;
    a_src   = '0;
    b_src   = '0;
    sum_src = '0;
    chunk   = '0;
    mask    = '0;
    part    = '0;
    cin     = 1'b0;
    w       = 0;
    for (int k = 0; k < STAGES; k++) begin
      w = chunk_width(k);
      if (k == 0) begin
        a_src      = bus.in_a;
        b_src      = bus.in_b;
        sum_src    = '0;
        cin        = 1'b0;
        valid_d[k] = accept;
      end else begin
        a_src      = a_q[k-1];
        b_src      = b_q[k-1];
        sum_src    = sum_q[k-1];
        cin        = carry_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      mask  = ~({(DATA_WIDTH + 1){1'b1}} << w);
      part  = ({1'b0, a_src} & mask) + ({1'b0, b_src} & mask) + {{DATA_WIDTH{1'b0}}, cin};
      chunk = part[DATA_WIDTH-1:0] & mask[DATA_WIDTH-1:0];
      // part < 2^(w+1), so anything left after shifting out w bits is the carry.
      carry_d[k] = |(part >> w);
      sum_d[k]   = (sum_src >> w) | (chunk << (DATA_WIDTH - w));
      a_d[k]     = a_src >> w;
      b_d[k]     = b_src >> w;
    end
  end

  // Pipeline registers: reset wins, otherwise every stage shifts together or holds together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

`ifdef PIPE_ADDER_STATS_EN
  logic        out_xfer;
  logic [31:0] op_count_q, carry_count_q;

  assign out_xfer = valid_q[STAGES-1] && bus.out_ready;

  // Saturating counts of delivered results and of those with carry-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q    <= '0;
      carry_count_q <= '0;
    end else if (out_xfer) begin
      if (op_count_q != 32'hFFFF_FFFF) op_count_q <= op_count_q + 32'd1;
      if (carry_q[STAGES-1] && (carry_count_q != 32'hFFFF_FFFF)) begin
        carry_count_q <= carry_count_q + 32'd1;
      end
    end
  end

  assign op_count_o    = op_count_q;
  assign carry_count_o = carry_count_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: 8-bit operands with 4, 3 and 1 stages.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_adder_if #(.DATA_WIDTH(8)) if4 ();
  pipe_adder_if #(.DATA_WIDTH(8)) if3 ();
  pipe_adder_if #(.DATA_WIDTH(8)) if1 ();

`ifdef PIPE_ADDER_STATS_EN
  logic [31:0] op4, cc4, op3, cc3, op1, cc1;
`endif

  pipe_adder #(.DATA_WIDTH(8), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4)
`ifdef PIPE_ADDER_STATS_EN
    , .op_count_o(op4), .carry_count_o(cc4)
`endif
  );
  pipe_adder #(.DATA_WIDTH(8), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3)
`ifdef PIPE_ADDER_STATS_EN
    , .op_count_o(op3), .carry_count_o(cc3)
`endif
  );
  pipe_adder #(.DATA_WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef PIPE_ADDER_STATS_EN
    , .op_count_o(op1), .carry_count_o(cc1)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result log for the 4-stage adder: every out transfer with the cycle it was seen in.
  logic [8:0] got_q[$];
  int         got_cyc[$];
  int         vcnt4 = 0;
  always @(negedge clk) begin
    if (if4.out_valid) vcnt4 <= vcnt4 + 1;
    if (if4.out_valid && if4.out_ready) begin
      got_q.push_back(if4.out_sum);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  // 3-stage sweep checker: results must arrive as a+b in index order a*256+b.
  int n3     = 0;
  int first3 = -1;
  always @(negedge clk) begin
    if (if3.out_valid && if3.out_ready) begin
      check("sweep_sum", 32'(if3.out_sum), 32'((n3 >> 8) + (n3 & 255)));
      if (n3 == 0) first3 <= cyc;
      n3 <= n3 + 1;
    end
  end

  int bp_a [6] = '{10, 255, 128, 1, 77, 200};
  int bp_b [6] = '{20, 255, 128, 2, 88, 55};
  int bp_s [6] = '{30, 510, 256, 3, 165, 255};
  int st_a [10] = '{200, 1, 128, 127, 255, 0, 50, 250, 3, 100};
  int st_b [10] = '{100, 1, 128, 128, 1, 0, 60, 250, 4, 100};
  int st_s [10] = '{300, 2, 256, 255, 256, 0, 110, 500, 7, 200};

  initial begin
    int base, vb, acc, idx, stall_left, start;
    bit stalled, acc_now;
    logic [8:0] held;

    if4.in_valid = 0; if4.in_a = 0; if4.in_b = 0; if4.out_ready = 1;
    if3.in_valid = 0; if3.in_a = 0; if3.in_b = 0; if3.out_ready = 1;
    if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.out_ready = 1;
    held = '0;

    rst = 1;
    step;
    step;
    rst = 0;
    check("rst_out_valid", 32'(if4.out_valid), 0);
    check("rst_out_sum", 32'(if4.out_sum), 0);
    check("rst_in_ready", 32'(if4.in_ready), 1);
    check("rst_out_valid_s1", 32'(if1.out_valid), 0);

    // Single op with carry into the MSB.
    base = got_q.size();
    vb   = vcnt4;
    if4.in_a = 8'd255; if4.in_b = 8'd1; if4.in_valid = 1;
    acc = cyc + 1;
    step;
    if4.in_valid = 0;
    repeat (8) step;
    check("single_count", 32'(got_q.size() - base), 1);
    check("single_sum", got_at(base), 256);
    check("single_latency", 32'(cyc_at(base) - acc), 3);
    check("single_valid_cycles", 32'(vcnt4 - vb), 1);

    // Back-to-back stream.
    base = got_q.size();
    if4.in_valid = 1;
    if4.in_a = 8'd100; if4.in_b = 8'd27;  step;
    if4.in_a = 8'd200; if4.in_b = 8'd100; step;
    if4.in_a = 8'd0;   if4.in_b = 8'd0;   step;
    if4.in_valid = 0;
    repeat (8) step;
    check("b2b_count", 32'(got_q.size() - base), 3);
    check("b2b_sum0", got_at(base), 127);
    check("b2b_sum1", got_at(base + 1), 300);
    check("b2b_sum2", got_at(base + 2), 0);
    check("b2b_consecutive", 32'(cyc_at(base + 2) - cyc_at(base)), 2);

    // Backpressure: 3-cycle stall as soon as the first result is presented.
    base = got_q.size();
    idx = 0; stall_left = 0; stalled = 0;
    for (int t = 0; t < 40; t++) begin
      if (!stalled && if4.out_valid) begin
        stalled    = 1;
        stall_left = 3;
        held       = if4.out_sum;
      end
      if4.out_ready = (stall_left == 0);
      if4.in_valid  = (idx < 6);
      if4.in_a      = 8'(bp_a[(idx < 6) ? idx : 0]);
      if4.in_b      = 8'(bp_b[(idx < 6) ? idx : 0]);
      #1;
      if (stall_left > 0) begin
        check("bp_in_ready", 32'(if4.in_ready), 0);
        check("bp_held_sum", 32'(if4.out_sum), 32'(held));
        stall_left--;
      end
      acc_now = if4.in_valid && if4.in_ready;
      step;
      if (acc_now) idx++;
    end
    if4.in_valid = 0;
    if4.out_ready = 1;
    check("bp_stall_seen", 32'(stalled), 1);
    check("bp_accepted", 32'(idx), 6);
    check("bp_count", 32'(got_q.size() - base), 6);
    for (int i = 0; i < 6; i++) check("bp_sum", got_at(base + i), 32'(bp_s[i]));

    // Reset mid-flight: nothing may emerge afterwards.
    base = got_q.size();
    if4.in_valid = 1;
    if4.in_a = 8'd1; if4.in_b = 8'd1; step;
    if4.in_a = 8'd2; if4.in_b = 8'd2; step;
    if4.in_a = 8'd3; if4.in_b = 8'd3; step;
    if4.in_valid = 0;
    rst = 1;
    step;
    rst = 0;
    check("midrst_in_ready", 32'(if4.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_out_valid", 32'(if4.out_valid), 0);
      step;
    end
    check("midrst_count", 32'(got_q.size() - base), 0);

    // Ten results, four with carry-out (also exercises the optional counters).
    base = got_q.size();
    if4.in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      if4.in_a = 8'(st_a[i]);
      if4.in_b = 8'(st_b[i]);
      step;
    end
    if4.in_valid = 0;
    repeat (8) step;
    check("stats_count", 32'(got_q.size() - base), 10);
    for (int i = 0; i < 10; i++) check("stats_sum", got_at(base + i), 32'(st_s[i]));
`ifdef PIPE_ADDER_STATS_EN
    check("op_count", op4, 10);
    check("carry_count", cc4, 4);
`endif
    rst = 1;
    step;
    rst = 0;
`ifdef PIPE_ADDER_STATS_EN
    check("op_count_rst", op4, 0);
    check("carry_count_rst", cc4, 0);
`endif

    // Single stage: sum visible right after the acceptance edge.
    if1.in_valid = 1;
    if1.in_a = 8'd200; if1.in_b = 8'd100;
    step;
    check("s1_valid", 32'(if1.out_valid), 1);
    check("s1_sum", 32'(if1.out_sum), 300);
    if1.in_a = 8'd255; if1.in_b = 8'd255;
    step;
    check("s1_sum_max", 32'(if1.out_sum), 510);
    if1.in_valid = 0;
    step;
    check("s1_idle", 32'(if1.out_valid), 0);

    // Three stages over 8 bits (chunks 3,3,2): exhaustive sweep.
    start = cyc;
    if3.in_valid = 1;
    for (int i = 0; i < 65536; i++) begin
      if3.in_a = 8'(i >> 8);
      if3.in_b = 8'(i);
      step;
    end
    if3.in_valid = 0;
    repeat (6) step;
    check("sweep_count", 32'(n3), 65536);
    check("sweep_latency", 32'(first3 - start), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
